inputdata_bram_loader: RTL
==========================

Name: inputdata_bram_loader

Overview:
Upstream feeder for the 1D convolution engine. It accepts a valid/ready stream of DW-bit EEG samples in channel-major order (all time steps of channel 0, then channel 1, and so on). It writes each sample into the convolution engine's input-data BRAM bank using the engine's layout:
- lane = ch % Dimension
- address = (ch / Dimension) * temporal_length + t

Its outputs connect directly to the engine's ena/wea/addr/data input-data write port.

Parameters:
DW, 16, sample width in bits
Dimension, 16, number of BRAM lanes
ADDRESS_LENGTH, 13, BRAM address width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; latches geometry and begins a load
input_channels  in  10  number of channels to load
temporal_length  in  10  samples per channel
s_data  in  DW  sample payload
s_valid  in  1  sample valid
s_ready  out  1  loader can accept a sample
ena_inputdata_input_bram  out  Dimension  one-hot BRAM enable
wea_inputdata_input_bram  out  Dimension  one-hot BRAM write enable
inputdata_bram_addr  out  ADDRESS_LENGTH  BRAM write address
inputdata_input_bram  out  DW*Dimension  write data, s_data replicated across all lanes
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when the last sample has been written
checksum  out  32  sample sum (see Optional Feature)

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM returns to IDLE.
  - All counters clear.
  - Every output goes to 0, including s_ready, busy, done and checksum.
  - A reset in the middle of a load aborts it with no further writes. The BRAM contents already written are left untouched.
- IDLE:
  - s_ready=0, busy=0.
  - A start pulse latches input_channels and temporal_length, and clears the channel counter ch, time counter t, slot base address base and lane index.
  - If either latched value is 0, go to DONE. No writes occur.
  - Otherwise go to LOAD.
- LOAD:
  - s_ready=1, busy=1.
  - A transfer occurs on each clock edge where s_valid&&s_ready.
  - On a transfer, on that same edge, register a one-cycle write:
    - ena = wea = (1 << lane)
    - addr = base + t
    - data = {Dimension{s_data}}
  - So the write appears on the outputs exactly one cycle after the handshake edge.
  - In cycles without a transfer, ena and wea return to 0. addr and data hold their values.
- Counter update on each transfer:
  - If t == temporal_length-1: t is cleared and ch increments.
    - If lane == Dimension-1: lane clears and base += temporal_length.
    - Otherwise: lane increments.
  - Otherwise: t increments.
  - base is computed by accumulation, with no multiplier, and wraps modulo 2^ADDRESS_LENGTH.
- End of load:
  - A transfer with ch == input_channels-1 and t == temporal_length-1 moves the FSM to DONE.
  - s_ready drops combinationally in DONE, so no extra sample is accepted.
- DONE:
  - Lasts one cycle: done=1, busy=1. The final write pulse is on the outputs in this same cycle.
  - Then return to IDLE.
- Start handling:
  - start while busy is ignored.
  - start in the same cycle as the DONE-to-IDLE transition is ignored. A new start is accepted only in IDLE.
- Back-pressure: the block never stalls internally. Throughput is 1 sample per clock while s_valid is held high.
- Latency from start to first s_ready: 1 cycle.
- Address range: no check against the BRAM depth. The upstream configuration keeps ceil(input_channels/Dimension) * temporal_length ≤ 2^ADDRESS_LENGTH.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- When defined:
  - checksum is a 32-bit register, cleared on an accepted start.
  - On each transfer it adds s_data, zero-extended, wrapping modulo 2^32.
  - The value is stable from the done pulse until the next start.
- When not defined: checksum is tied to 0 and no accumulator is synthesised.

Test Plan:
- 1 channel, length 16, samples 0..15 streamed back-to-back:
  - 16 writes, ena=16'h0001, addr 0..15, data lanes all equal to the sample.
  - done pulses 1 cycle after the last handshake.
  - checksum=120 when LOADER_CHECKSUM_EN is defined.
- 32 channels, length 64, value = ch*100+t:
  - Channel 17, t=5 is written with ena=16'h0002, addr=69, data=1705.
  - 2048 writes total.
- 4 channels, length 16, s_valid toggling every other cycle:
  - A write occurs only after each handshake, with no duplicate or missing address.
  - busy stays high throughout.
- input_channels=0 with temporal_length=16, then input_channels=3 with temporal_length=0:
  - Each start yields done one cycle after IDLE→DONE.
  - s_ready never rises and no writes occur.
- Start pulsed again mid-load (1 channel, length 8):
  - Ignored; the load completes with exactly 8 writes.
- rst asserted after 5 of 16 samples:
  - All outputs are 0 immediately.
  - A subsequent start/load restarts at addr 0.

Source files
------------

// File: rtl/inputdata_bram_loader.sv
// Streams channel-major samples into the conv engine input-data BRAM bank.
// Optional sample checksum accumulator: define LOADER_CHECKSUM_EN.
module inputdata_bram_loader #(
  parameter int DW             = 16,
  parameter int Dimension      = 16,
  parameter int ADDRESS_LENGTH = 13
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [9:0]                  input_channels,
  input  logic [9:0]                  temporal_length,
  input  logic [DW-1:0]               s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [Dimension-1:0]        ena_inputdata_input_bram,
  output logic [Dimension-1:0]        wea_inputdata_input_bram,
  output logic [ADDRESS_LENGTH-1:0]   inputdata_bram_addr,
  output logic [DW*Dimension-1:0]     inputdata_input_bram,
  output logic                        busy,
  output logic                        done,
  output logic [31:0]                 checksum
);

  localparam int LW = (Dimension > 1) ? $clog2(Dimension) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]                state_q;
  logic [9:0]                ic_q;
  logic [9:0]                tl_q;
  logic [9:0]                ch_q;
  logic [9:0]                t_q;
  logic [ADDRESS_LENGTH-1:0] base_q;
  logic [LW-1:0]             lane_q;
  logic [Dimension-1:0]      ena_q;
  logic [ADDRESS_LENGTH-1:0] addr_q;
  logic [DW*Dimension-1:0]   data_q;
  logic [Dimension-1:0]      lane_oh;
  logic                      xfer;
  logic                      last_t;
  logic                      last_ch;

  assign s_ready = (state_q == S_LOAD);
  assign busy    = (state_q == S_LOAD) || (state_q == S_DONE);
  assign done    = (state_q == S_DONE);
  assign xfer    = s_valid && s_ready;
  assign last_t  = (t_q == tl_q - 10'd1);
  assign last_ch = (ch_q == ic_q - 10'd1);

  assign ena_inputdata_input_bram = ena_q;
  assign wea_inputdata_input_bram = ena_q;
  assign inputdata_bram_addr      = addr_q;
  assign inputdata_input_bram     = data_q;

  // Decode the current lane into a one-hot write strobe.
  always_comb begin
    lane_oh         = '0;
    lane_oh[lane_q] = 1'b1;
  end

  // Load sequencer: geometry latch, channel/time/lane counters, slot base.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ic_q    <= '0;
      tl_q    <= '0;
      ch_q    <= '0;
      t_q     <= '0;
      base_q  <= '0;
      lane_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            ic_q   <= input_channels;
            tl_q   <= temporal_length;
            ch_q   <= '0;
            t_q    <= '0;
            base_q <= '0;
            lane_q <= '0;
            if (input_channels == 10'd0 ||
                temporal_length == 10'd0)
              state_q <= S_DONE;
            else
              state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (xfer) begin
            if (last_t) begin
              t_q  <= '0;
              ch_q <= ch_q + 10'd1;
              if (lane_q == LW'(Dimension - 1)) begin
                lane_q <= '0;
                base_q <= base_q +
                          ADDRESS_LENGTH'(tl_q);
              end else begin
                lane_q <= lane_q + LW'(1);
              end
              if (last_ch)
                state_q <= S_DONE;
            end else begin
              t_q <= t_q + 10'd1;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Register a one-cycle BRAM write for every accepted sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ena_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else if (xfer) begin
      ena_q  <= lane_oh;
      addr_q <= base_q + ADDRESS_LENGTH'(t_q);
      data_q <= {Dimension{s_data}};
    end else begin
      ena_q  <= '0;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum_q;

  assign checksum = sum_q;

  // Running sum of accepted samples, restarted by each accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      sum_q <= '0;
    else if (state_q == S_IDLE && start)
      sum_q <= '0;
    else if (xfer)
      sum_q <= sum_q + 32'(s_data);
  end
`else
  assign checksum = 32'd0;
`endif

endmodule
